// File: rtl/arm_inst_encoder.sv
// Packs ARM instruction fields into 32-bit words and streams them into instruction memory.
// Optional: define ENC_NOP_SLOT_EN to follow every branch with an automatic NOP word.
module arm_inst_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        kind,
    input  logic [3:0]        cond,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic              load,
    input  logic              up,
    input  logic [1:0]        size,
    input  logic              link,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       operand2,
    input  logic [23:0]       offset24,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_data,
    output logic [ADDR_W-1:0] word_count,
    output logic              full,
    output logic              err
);

`ifdef ENC_NOP_SLOT_EN
    typedef enum logic [1:0] {IDLE, SLOT, FULL} state_t;
`else
    typedef enum logic [1:0] {IDLE, FULL} state_t;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    state_t            state_q, state_d;
    logic              we_d, err_d;
    logic [ADDR_W-1:0] addr_d, cnt_d;
    logic [31:0]       data_d;
    logic [31:0]       enc;
    logic              legal, is_br, accept;
    logic [ADDR_W-1:0] cnt_inc, wr_addr;

    assign full      = (word_count == DEPTH_W);
    assign req_ready = (state_q == IDLE) & ~full & ~reset & ~clear;
    assign accept    = req_valid & req_ready;
    assign cnt_inc   = word_count + 1'b1;
    assign wr_addr   = word_count << 2;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        is_br = 1'b0;
        unique case (kind)
            3'b000, 3'b001: enc = {cond, kind, opcode, s_bit, rn, rd, operand2};
            // LS words are always pre-indexed, so P is forced high
            3'b010, 3'b011: enc = {cond, kind, 1'b1, up, size, load, rn, rd, operand2};
            3'b101: begin
                enc   = {cond, 3'b101, link, offset24};
                is_br = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        addr_d  = im_addr;
        data_d  = im_data;
        cnt_d   = word_count;
        if (clear) begin
            state_d = IDLE;
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && legal) begin
                        we_d   = 1'b1;
                        addr_d = wr_addr;
                        data_d = enc;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == DEPTH_W) begin
                            state_d = FULL;
`ifdef ENC_NOP_SLOT_EN
                            err_d   = is_br;
`endif
                        end
`ifdef ENC_NOP_SLOT_EN
                        else if (is_br) begin
                            state_d = SLOT;
                        end
`endif
                    end else if (accept) begin
                        err_d = 1'b1;
                    end
                end
`ifdef ENC_NOP_SLOT_EN
                SLOT: begin
                    we_d    = 1'b1;
                    addr_d  = wr_addr;
                    data_d  = '0;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == DEPTH_W) ? FULL : IDLE;
                end
`endif
                FULL: state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            im_we      <= 1'b0;
            err        <= 1'b0;
            im_addr    <= '0;
            im_data    <= '0;
            word_count <= '0;
        end else begin
            state_q    <= state_d;
            im_we      <= we_d;
            err        <= err_d;
            im_addr    <= addr_d;
            im_data    <= data_d;
            word_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Scoreboard bench for arm_inst_encoder: directed vectors then randomized fields.
// Follows ENC_NOP_SLOT_EN the same way the design does.
module tb_arm_inst_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset, clear, req_valid, req_ready;
    logic [2:0]        kind;
    logic [3:0]        cond, opcode, rn, rd;
    logic              s_bit, load, up, link;
    logic [1:0]        size;
    logic [11:0]       operand2;
    logic [23:0]       offset24;
    logic              im_we, full, err;
    logic [ADDR_W-1:0] im_addr, word_count;
    logic [31:0]       im_data;

    arm_inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .kind(kind), .cond(cond), .opcode(opcode), .s_bit(s_bit),
        .load(load), .up(up), .size(size), .link(link),
        .rn(rn), .rd(rd), .operand2(operand2), .offset24(offset24),
        .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
        .word_count(word_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  cond, opcode, rn, rd;
        logic        s_bit, load, up, link;
        logic [1:0]  size;
        logic [11:0] op2;
        logic [23:0] off;
    } fld_t;

    typedef struct {
        logic        we;
        logic        err;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  m_cnt = 0;
    bit  m_slot = 0;
    bit  started = 0;

`ifdef ENC_NOP_SLOT_EN
    localparam bit SLOT_EN = 1'b1;
`else
    localparam bit SLOT_EN = 1'b0;
`endif

    function automatic logic [31:0] ref_word(fld_t f);
        logic [31:0] w;
        w = 32'(f.cond) << 28;
        if (f.kind <= 3'd1)
            w = w + (32'(f.kind) << 25) + (32'(f.opcode) << 21) + (32'(f.s_bit) << 20)
                  + (32'(f.rn) << 16) + (32'(f.rd) << 12) + 32'(f.op2);
        else if (f.kind <= 3'd3)
            w = w + (32'(f.kind) << 25) + (32'd1 << 24) + (32'(f.up) << 23)
                  + (32'(f.size) << 21) + (32'(f.load) << 20)
                  + (32'(f.rn) << 16) + (32'(f.rd) << 12) + 32'(f.op2);
        else
            w = w + (32'd5 << 25) + (32'(f.link) << 24) + 32'(f.off);
        return w;
    endfunction

    function automatic bit is_legal(logic [2:0] k);
        return (k <= 3'd3) || (k == 3'd5);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(bit v, bit rst, bit clr, fld_t f, bit use_lit, logic [31:0] lit);
        bit   rdy;
        ev_t  e;
        @(posedge clk);
        #1;
        req_valid = v; reset = rst; clear = clr;
        kind = f.kind; cond = f.cond; opcode = f.opcode; s_bit = f.s_bit;
        load = f.load; up = f.up; size = f.size; link = f.link;
        rn = f.rn; rd = f.rd; operand2 = f.op2; offset24 = f.off;
        #1;
        rdy = !m_slot && (m_cnt < DEPTH) && !rst && !clr;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("word_count", 32'(word_count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        if (rst || clr) begin
            m_cnt = 0; m_slot = 0;
        end else if (m_slot) begin
            e = '{we: 1'b1, err: 1'b0, addr: 8'(m_cnt * 4), data: 32'h0};
            q.push_back(e);
            m_cnt++; m_slot = 0;
        end else if (v && rdy) begin
            if (!is_legal(f.kind)) begin
                e = '{we: 1'b0, err: 1'b1, addr: 8'h0, data: 32'h0};
            end else begin
                e = '{we: 1'b1, err: 1'b0, addr: 8'(m_cnt * 4),
                      data: use_lit ? lit : ref_word(f)};
                m_cnt++;
                if (SLOT_EN && f.kind == 3'd5) begin
                    if (m_cnt == DEPTH) e.err = 1'b1;
                    else m_slot = 1;
                end
            end
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (started && (im_we === 1'b1 || err === 1'b1)) begin
            if (q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_output: we=%b err=%b addr=%h data=%h expected none",
                         im_we, err, im_addr, im_data);
            end else begin
                e = q.pop_front();
                chk("im_we", 32'(im_we), 32'(e.we));
                chk("err", 32'(err), 32'(e.err));
                if (e.we) begin
                    chk("im_addr", 32'(im_addr), 32'(e.addr));
                    chk("im_data", im_data, e.data);
                end
            end
        end
    end

    function automatic fld_t zf();
        fld_t f;
        f = '{kind: 3'd0, cond: 4'd0, opcode: 4'd0, rn: 4'd0, rd: 4'd0,
              s_bit: 1'b0, load: 1'b0, up: 1'b0, link: 1'b0, size: 2'd0,
              op2: 12'd0, off: 24'd0};
        return f;
    endfunction

    function automatic fld_t rf();
        fld_t f;
        f.kind = 3'($urandom_range(0, 7));
        f.cond = 4'($urandom); f.opcode = 4'($urandom);
        f.rn = 4'($urandom); f.rd = 4'($urandom);
        f.s_bit = 1'($urandom); f.load = 1'($urandom);
        f.up = 1'($urandom); f.link = 1'($urandom);
        f.size = 2'($urandom); f.op2 = 12'($urandom); f.off = 24'($urandom);
        return f;
    endfunction

    initial begin
        fld_t f;
        reset = 1'b1; clear = 1'b0; req_valid = 1'b0;
        f = zf();
        kind = 0; cond = 0; opcode = 0; s_bit = 0; load = 0; up = 0; size = 0;
        link = 0; rn = 0; rd = 0; operand2 = 0; offset24 = 0;
        repeat (3) @(posedge clk);
        #2;
        started = 1;
        chk("reset_im_we", 32'(im_we), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_im_data", im_data, 32'd0);
        chk("reset_im_addr", 32'(im_addr), 32'd0);

        f = zf(); f.kind = 3'd1; f.cond = 4'hE; f.opcode = 4'd4; f.s_bit = 1;
        f.rn = 4'd1; f.rd = 4'd2; f.op2 = 12'h0FF;
        step(1, 0, 0, f, 1, 32'hE29120FF);
        f = zf(); f.kind = 3'd2; f.cond = 4'hE; f.up = 1; f.load = 1;
        f.rn = 4'd3; f.rd = 4'd4; f.op2 = 12'h004;
        step(1, 0, 0, f, 1, 32'hE5934004);
        f.up = 0; f.load = 0;
        step(1, 0, 0, f, 1, 32'hE5034004);
        f = zf(); f.kind = 3'd6;
        step(1, 0, 0, f, 0, 32'h0);
        f = zf();
        step(1, 0, 0, f, 1, 32'h0);
        step(0, 0, 0, f, 0, 32'h0);
        step(0, 0, 1, f, 0, 32'h0);
        f = zf(); f.kind = 3'd5; f.cond = 4'hE; f.link = 1; f.off = 24'h000010;
        step(1, 0, 0, f, 1, 32'hEB000010);
        for (int i = 0; i < 6; i++) begin
            f = rf(); f.kind = 3'd0;
            step(1, 0, 0, f, 0, 32'h0);
        end
        step(0, 0, 1, f, 0, 32'h0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, f, 0, 32'h0);
        step(1, 1, 0, f, 0, 32'h0);
        step(0, 0, 0, f, 0, 32'h0);
        chk("rst_mid_im_data", im_data, 32'd0);
        chk("rst_mid_im_addr", 32'(im_addr), 32'd0);
        chk("rst_mid_im_we", 32'(im_we), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            f = rf();
            step(($urandom_range(0, 9) < 7), (r < 2), (r >= 2 && r < 7), f, 0, 32'h0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, f, 0, 32'h0);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
